// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bus between the ID stage and the hazard stall unit.
// The master side presents the decoded ID-stage instruction and the data
// memory ready flag. The slave side, the hazard unit, returns the pipeline
// write enables, flushes, freeze and the stall-cycle counter.
interface hazard_stall_unit_if #(
    parameter int AddressSize  = 5,
    parameter int CounterWidth = 16
);

    // ID-stage instruction information
    logic [AddressSize-1:0]  IDRs1;
    logic [AddressSize-1:0]  IDRs2;
    logic                    IDUsesRs1;
    logic                    IDUsesRs2;
    logic                    IDIsBranch;
    logic                    IDBranchTaken;
    logic [AddressSize-1:0]  IDRd;
    logic                    IDRegWrite;
    logic                    IDMemRead;
    logic                    IDMemWrite;

    // Data memory handshake
    logic                    dmemReady;

    // Pipeline control returned by the hazard unit
    logic                    PCWrite;
    logic                    IFIDWrite;
    logic                    IDEXFlush;
    logic                    IFIDFlush;
    logic                    freeze;
    logic [CounterWidth-1:0] stallCount;

    // Pipeline side: drives the ID instruction, consumes the controls
    modport master (
        output IDRs1, IDRs2, IDUsesRs1, IDUsesRs2, IDIsBranch, IDBranchTaken,
        output IDRd, IDRegWrite, IDMemRead, IDMemWrite, dmemReady,
        input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, freeze, stallCount
    );

    // Hazard unit side
    modport slave (
        input  IDRs1, IDRs2, IDUsesRs1, IDUsesRs2, IDIsBranch, IDBranchTaken,
        input  IDRd, IDRegWrite, IDMemRead, IDMemWrite, dmemReady,
        output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, freeze, stallCount
    );

endinterface : hazard_stall_unit_if

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard stall unit for the 5-stage core.
// Keeps a shadow copy of the destination/load information of the
// instructions in EX and MEM and stalls the front end for every hazard that
// forwarding cannot cover: load-use, branch-in-ID operand dependencies and a
// data memory that has not completed its access. All pipeline controls are
// combinational from the shadow state and the current ID inputs; the shadows
// and the stall counter advance on the rising clock edge.
module hazard_stall_unit #(
    parameter int AddressSize  = 5,
    parameter int CounterWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  bus
);

    // Per-stage shadow of what the downstream pipeline registers hold.
    typedef struct packed {
        logic [AddressSize-1:0] rd;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_access;  // read or write in flight
    } shadow_t;

    // Cycle outcome; reset has the highest priority, then memory wait,
    // then data hazard, else the pipeline advances.
    typedef enum logic [1:0] {
        DecRun,
        DecHazard,
        DecWait,
        DecReset
    } decision_e;

    localparam shadow_t Bubble = '0;

    shadow_t                 ex_q, ex_d;
    shadow_t                 mem_q, mem_d;
    shadow_t                 id_fields;
    logic [CounterWidth-1:0] stall_cnt_q, stall_cnt_d;

    logic      ex_src_match;
    logic      mem_src_match;
    logic      load_use;
    logic      br_ex;
    logic      br_mem_load;
    logic      hazard;
    logic      mem_wait;
    decision_e decision;

    // Compare the ID sources against the EX and MEM destinations; x0 never matches.
    always_comb begin
        ex_src_match  = (ex_q.rd != '0) &&
                        ((bus.IDUsesRs1 && (ex_q.rd == bus.IDRs1)) ||
                         (bus.IDUsesRs2 && (ex_q.rd == bus.IDRs2)));
        mem_src_match = (mem_q.rd != '0) &&
                        ((bus.IDUsesRs1 && (mem_q.rd == bus.IDRs1)) ||
                         (bus.IDUsesRs2 && (mem_q.rd == bus.IDRs2)));
    end

    // Classify the hazards that forwarding cannot resolve.
    always_comb begin
        // A load in EX delivers its data too late for any consumer in ID.
        load_use    = ex_q.mem_read && ex_q.reg_write && ex_src_match;
        // Branches compare in ID, so anything still in EX is too late.
        br_ex       = bus.IDIsBranch && ex_q.reg_write && ex_src_match;
        // MEM-to-ID forwarding carries the ALU result only, not load data.
        br_mem_load = bus.IDIsBranch && mem_q.mem_read && mem_q.reg_write &&
                      mem_src_match;
        hazard      = load_use || br_ex || br_mem_load;
        // A ready flag without an access in MEM means nothing.
        mem_wait    = mem_q.mem_access && !bus.dmemReady;
    end

    // Resolve the priority between reset, memory wait and hazard.
    always_comb begin
        if (rst) begin
            decision = DecReset;
        end else if (mem_wait) begin
            decision = DecWait;
        end else if (hazard) begin
            decision = DecHazard;
        end else begin
            decision = DecRun;
        end
    end

    // Drive the pipeline write enables, flushes and freeze for this cycle.
    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves
        // one unassigned; otherwise synthesis would infer a latch.
        bus.PCWrite   = 1'b0;
        bus.IFIDWrite = 1'b0;
        bus.IDEXFlush = 1'b0;
        bus.IFIDFlush = 1'b0;
        bus.freeze    = 1'b0;
        unique case (decision)
            DecReset: begin
                bus.IDEXFlush = 1'b1;
            end
            DecWait: begin
                bus.freeze = 1'b1;
            end
            DecHazard: begin
                bus.IDEXFlush = 1'b1;
            end
            DecRun: begin
                bus.PCWrite   = 1'b1;
                bus.IFIDWrite = 1'b1;
                // A stalled taken branch only squashes IF/ID once it advances.
                bus.IFIDFlush = bus.IDBranchTaken;
            end
            default: begin
                bus.IDEXFlush = 1'b1;
            end
        endcase
    end

    // Collect the ID-stage fields that move into EX when the pipeline advances.
    always_comb begin
        id_fields.rd         = bus.IDRd;
        id_fields.reg_write  = bus.IDRegWrite;
        id_fields.mem_read   = bus.IDMemRead;
        id_fields.mem_access = bus.IDMemRead || bus.IDMemWrite;
    end

    // Next shadow state and stall counter.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        stall_cnt_d = stall_cnt_q;
        unique case (decision)
            DecWait: begin
                // Whole back end frozen: shadows hold, the cycle is a stall.
                stall_cnt_d = stall_cnt_q + CounterWidth'(1);
            end
            DecHazard: begin
                // Bubble enters EX while the older instruction moves on.
                ex_d        = Bubble;
                mem_d       = ex_q;
                stall_cnt_d = stall_cnt_q + CounterWidth'(1);
            end
            DecRun: begin
                ex_d  = id_fields;
                mem_d = ex_q;
            end
            default: begin
                // Reset is applied in the register block below.
            end
        endcase
    end

    // Register the shadows and counter; reset clears to bubbles and zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (rst) begin
            ex_q        <= Bubble;
            mem_q       <= Bubble;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stallCount = stall_cnt_q;

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit. Each cycle's stimulus carries a
// hand-derived expectation for the control outputs; that expectation and the
// expected stall count are queued when the stimulus is driven and compared on
// the following falling edge. A second instance with a 4-bit counter sees the
// same stimulus so counter wrap is checked as well.
module tb_hazard_stall_unit;

    // Expected {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, freeze}
    localparam logic [4:0] RUN    = 5'b11000;
    localparam logic [4:0] RUN_FL = 5'b11010;
    localparam logic [4:0] STALL  = 5'b00100;
    localparam logic [4:0] WAIT   = 5'b00001;
    localparam logic [4:0] RESET  = 5'b00100;

    typedef struct {
        string       tag;
        logic [4:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [15:0] exp_cnt = '0;

    hazard_stall_unit_if #(.AddressSize(5), .CounterWidth(16)) bus ();
    hazard_stall_unit_if #(.AddressSize(5), .CounterWidth(4))  bus4 ();

    hazard_stall_unit #(.AddressSize(5), .CounterWidth(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    hazard_stall_unit #(.AddressSize(5), .CounterWidth(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: outputs are combinational, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".ctrl"},
                  32'({bus.PCWrite, bus.IFIDWrite, bus.IDEXFlush, bus.IFIDFlush, bus.freeze}),
                  32'(e.ctrl));
            check({e.tag, ".cnt16"}, 32'(bus.stallCount), 32'(e.cnt));
            check({e.tag, ".cnt4"},  32'(bus4.stallCount), 32'(e.cnt[3:0]));
        end
    end

    // One clock cycle: drive the ID instruction, queue the expectation,
    // then advance past the next rising edge.
    task automatic cyc(input string tag, input logic r, input logic rdy,
                       input int rs1, input logic u1, input int rs2, input logic u2,
                       input logic br, input logic tk,
                       input int rd, input logic rw, input logic mr, input logic mw,
                       input logic [4:0] exp_ctrl);
        exp_t e;
        rst                = r;
        bus.dmemReady      = rdy;  bus4.dmemReady      = rdy;
        bus.IDRs1          = 5'(rs1); bus4.IDRs1       = 5'(rs1);
        bus.IDUsesRs1      = u1;   bus4.IDUsesRs1      = u1;
        bus.IDRs2          = 5'(rs2); bus4.IDRs2       = 5'(rs2);
        bus.IDUsesRs2      = u2;   bus4.IDUsesRs2      = u2;
        bus.IDIsBranch     = br;   bus4.IDIsBranch     = br;
        bus.IDBranchTaken  = tk;   bus4.IDBranchTaken  = tk;
        bus.IDRd           = 5'(rd); bus4.IDRd         = 5'(rd);
        bus.IDRegWrite     = rw;   bus4.IDRegWrite     = rw;
        bus.IDMemRead      = mr;   bus4.IDMemRead      = mr;
        bus.IDMemWrite     = mw;   bus4.IDMemWrite     = mw;
        e.tag  = tag;
        e.ctrl = exp_ctrl;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (r) begin
            exp_cnt = '0;
        end else if (!exp_ctrl[4]) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.dmemReady = 1'b1; bus4.dmemReady = 1'b1;
        @(posedge clk);
        #1;

        //  tag            r rdy rs1 u1 rs2 u2 br tk rd rw mr mw  expected
        cyc("rst0",        1,1,  0,0, 0,0, 0,0, 0,0,0,0, RESET);
        cyc("rst1",        1,1,  5,1, 5,1, 1,1, 5,1,1,0, RESET);

        // load then dependent use through Rs2: one stall
        cyc("lu.lw",       0,1,  0,0, 0,0, 0,0, 5,1,1,0, RUN);
        cyc("lu.use",      0,1,  1,1, 5,1, 0,0, 6,1,0,0, STALL);
        cyc("lu.adv",      0,1,  1,1, 5,1, 0,0, 6,1,0,0, RUN);
        cyc("lu.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // ALU then dependent branch: one stall
        cyc("ba.add",      0,1,  0,0, 0,0, 0,0, 7,1,0,0, RUN);
        cyc("ba.beq",      0,1,  7,1, 1,1, 1,0, 0,0,0,0, STALL);
        cyc("ba.adv",      0,1,  7,1, 1,1, 1,0, 0,0,0,0, RUN);
        cyc("ba.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // load then dependent branch: two stalls
        cyc("bl.lw",       0,1,  0,0, 0,0, 0,0, 7,1,1,0, RUN);
        cyc("bl.beq1",     0,1,  1,1, 7,1, 1,0, 0,0,0,0, STALL);
        cyc("bl.beq2",     0,1,  1,1, 7,1, 1,0, 0,0,0,0, STALL);
        cyc("bl.adv",      0,1,  1,1, 7,1, 1,0, 0,0,0,0, RUN);
        cyc("bl.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // x0 destination and an unused matching source: no stall
        cyc("x0.lw",       0,1,  0,0, 0,0, 0,0, 0,1,1,0, RUN);
        cyc("x0.use",      0,1,  0,1, 0,1, 0,0, 3,1,0,0, RUN);
        cyc("un.lw",       0,1,  0,0, 0,0, 0,0, 5,1,1,0, RUN);
        cyc("un.use",      0,1,  5,0, 2,1, 0,0, 4,1,0,0, RUN);
        cyc("un.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // memory wait beats a pending load-use, which is still seen afterwards
        cyc("mw.lw8",      0,1,  0,0, 0,0, 0,0, 8,1,1,0, RUN);
        cyc("mw.lw9",      0,1,  0,0, 0,0, 0,0, 9,1,1,0, RUN);
        cyc("mw.w1",       0,0,  9,1, 0,0, 0,0, 3,1,0,0, WAIT);
        cyc("mw.w2",       0,0,  9,1, 0,0, 0,0, 3,1,0,0, WAIT);
        cyc("mw.w3",       0,0,  9,1, 0,0, 0,0, 3,1,0,0, WAIT);
        cyc("mw.lu",       0,1,  9,1, 0,0, 0,0, 3,1,0,0, STALL);
        cyc("mw.adv",      0,1,  9,1, 0,0, 0,0, 3,1,0,0, RUN);
        cyc("mw.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // taken branch, first free then stalled one cycle
        cyc("tb.free",     0,1,  1,1, 2,1, 1,1, 0,0,0,0, RUN_FL);
        cyc("tb.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);
        cyc("ts.add",      0,1,  0,0, 0,0, 0,0, 7,1,0,0, RUN);
        cyc("ts.stall",    0,1,  7,1, 1,1, 1,1, 0,0,0,0, STALL);
        cyc("ts.adv",      0,1,  7,1, 1,1, 1,1, 0,0,0,0, RUN_FL);
        cyc("ts.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // reset in the middle of a load-use stall
        cyc("rs.lw",       0,1,  0,0, 0,0, 0,0, 5,1,1,0, RUN);
        cyc("rs.stall",    0,1,  5,1, 0,0, 0,0, 6,1,0,0, STALL);
        cyc("rs.rst",      1,1,  5,1, 0,0, 0,0, 6,1,0,0, RESET);
        cyc("rs.after",    0,1,  5,1, 0,0, 0,0, 6,1,0,0, RUN);
        cyc("rs.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        // 17 memory-wait cycles: the 4-bit counter wraps to 1
        cyc("wr.lw",       0,1,  0,0, 0,0, 0,0, 10,1,1,0, RUN);
        cyc("wr.nop",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);
        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("wr.wait%0d", i), 0,0, 0,0, 0,0, 0,0, 0,0,0,0, WAIT);
        end
        cyc("wr.rdy",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);
        cyc("wr.end",      0,1,  0,0, 0,0, 0,0, 0,0,0,0, RUN);

        @(negedge clk);
        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_stall_unit
